// File: rtl/gpr_file_mp_if.sv
// rtl/gpr_file_mp_if.sv - port bundle between the MIPS datapath and gpr_file_mp
//
// Signals (master = datapath, slave = register file):
//   ra/rb/rc_addr  master->slave  read addresses (rs, rt, aux)
//   ra/rb/rc_data  slave->master  combinational read data
//   ra/rb/rc_busy  slave->master  scoreboard busy bit of the addressed register
//   w0_en/addr/data master->slave ALU writeback
//   w1_en/addr/data master->slave load writeback, also clears busy[w1_addr]
//   bs_en/bs_addr  master->slave  load issued, sets busy[bs_addr]
//   err_waw        slave->master  sticky write-after-write hazard flag
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [ADDR_W-1:0] rc_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] rc_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              rc_busy;
  logic              w0_en;
  logic [ADDR_W-1:0] w0_addr;
  logic [DATA_W-1:0] w0_data;
  logic              w1_en;
  logic [ADDR_W-1:0] w1_addr;
  logic [DATA_W-1:0] w1_data;
  logic              bs_en;
  logic [ADDR_W-1:0] bs_addr;
  logic              err_waw;

  modport master (
    output ra_addr, rb_addr, rc_addr,
    output w0_en, w0_addr, w0_data,
    output w1_en, w1_addr, w1_data,
    output bs_en, bs_addr,
    input  ra_data, rb_data, rc_data,
    input  ra_busy, rb_busy, rc_busy,
    input  err_waw
  );

  modport slave (
    input  ra_addr, rb_addr, rc_addr,
    input  w0_en, w0_addr, w0_data,
    input  w1_en, w1_addr, w1_data,
    input  bs_en, bs_addr,
    output ra_data, rb_data, rc_data,
    output ra_busy, rb_busy, rc_busy,
    output err_waw
  );
endinterface

// File: rtl/gpr_file_mp.sv
// rtl/gpr_file_mp.sv - multi-port MIPS register file with load busy scoreboard
//
// Three combinational read ports, two write ports (w0 = ALU, w1 = load, w1 wins
// on an address collision), a per-register busy bit for outstanding loads and a
// sticky write-after-write error flag.
//
// Ports:
//   clk    posedge clock for all state
//   reset  asynchronous, active-high; clears registers, busy bits and err_waw
//   bus    gpr_file_mp_if.slave bundle (read, write, scoreboard, err_waw)
//
// Parameters: DATA_W register width, ADDR_W address width (2**ADDR_W entries),
// ZERO_REG = 1 makes register 0 a hardwired zero.
//
// Build option: define GPR_BYPASS_EN to forward same-cycle write data (and the
// same-cycle busy clear from w1) onto the read ports. Without it, reads and
// busy come purely from registered state.
module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset,
  gpr_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NRD   = 3;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              err_q;

  // True for the hardwired-zero register: never written, never busy, never forwarded.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic w0_ok;
  logic w1_ok;
  logic bs_ok;

  assign w0_ok = bus.w0_en && !is_zero(bus.w0_addr);
  assign w1_ok = bus.w1_en && !is_zero(bus.w1_addr);
  assign bs_ok = bus.bs_en && !is_zero(bus.bs_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      // w1 is assigned last so the load result wins an address collision.
      if (w0_ok) regs[bus.w0_addr] <= bus.w0_data;
      if (w1_ok) regs[bus.w1_addr] <= bus.w1_data;
      // Set after clear: a load issued in the same cycle another one returns
      // to that register keeps it busy.
      if (bus.w1_en) busy[bus.w1_addr] <= 1'b0;
      if (bs_ok)     busy[bus.bs_addr] <= 1'b1;
      // The ALU write still lands; the flag only records the hazard.
      if (w0_ok && busy[bus.w0_addr]) err_q <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] rd_addr [NRD];
  logic [DATA_W-1:0] rd_data [NRD];
  logic              rd_busy [NRD];

  assign rd_addr[0] = bus.ra_addr;
  assign rd_addr[1] = bus.rb_addr;
  assign rd_addr[2] = bus.rc_addr;

  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
`ifdef GPR_BYPASS_EN
      if (!is_zero(rd_addr[p])) begin
        if (bus.w1_en && (bus.w1_addr == rd_addr[p])) begin
          rd_data[p] = bus.w1_data;
          rd_busy[p] = 1'b0;
        end else if (bus.w0_en && (bus.w0_addr == rd_addr[p])) begin
          rd_data[p] = bus.w0_data;
        end
      end
`endif
      // Reset also masks any forwarded write data on the read ports.
      if (reset || is_zero(rd_addr[p])) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.ra_data = rd_data[0];
  assign bus.rb_data = rd_data[1];
  assign bus.rc_data = rd_data[2];
  assign bus.ra_busy = rd_busy[0];
  assign bus.rb_busy = rd_busy[1];
  assign bus.rc_busy = rd_busy[2];
  assign bus.err_waw = err_q;

endmodule

// File: tb/tb_gpr_file_mp.sv
// tb/tb_gpr_file_mp.sv - self-checking bench for gpr_file_mp
module tb_gpr_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  gpr_file_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain array contents, busy flags and the sticky error.
  logic [DW-1:0] m_regs [N];
  logic          m_busy [N];
  logic          m_err;

  typedef struct {
    logic          w0_en;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;
    logic          w1_en;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;
    logic          bs_en;
    logic [AW-1:0] bs_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] exp_data;
    logic          exp_busy;
    logic          exp_err;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_clock();
    if (bus.w0_en && bus.w0_addr != 0 && m_busy[bus.w0_addr]) m_err = 1'b1;
    if (bus.w0_en && bus.w0_addr != 0) m_regs[bus.w0_addr] = bus.w0_data;
    if (bus.w1_en && bus.w1_addr != 0) m_regs[bus.w1_addr] = bus.w1_data;
    if (bus.w1_en) m_busy[bus.w1_addr] = 1'b0;
    if (bus.bs_en && bus.bs_addr != 0) m_busy[bus.bs_addr] = 1'b1;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (reset || a == 0) return '0;
`ifdef GPR_BYPASS_EN
    if (bus.w1_en && bus.w1_addr == a) return bus.w1_data;
    if (bus.w0_en && bus.w0_addr == a) return bus.w0_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (reset || a == 0) return 1'b0;
`ifdef GPR_BYPASS_EN
    if (bus.w1_en && bus.w1_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic idle();
    bus.w0_en = 1'b0; bus.w0_addr = '0; bus.w0_data = '0;
    bus.w1_en = 1'b0; bus.w1_addr = '0; bus.w1_data = '0;
    bus.bs_en = 1'b0; bus.bs_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    bus.ra_addr = a; bus.rb_addr = b; bus.rc_addr = c;
  endtask

  // One clock: model follows the DUT's edge, inputs change 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ra_data"}, bus.ra_data, exp_data(bus.ra_addr));
    chk({tag, " rb_data"}, bus.rb_data, exp_data(bus.rb_addr));
    chk({tag, " rc_data"}, bus.rc_data, exp_data(bus.rc_addr));
    chk({tag, " ra_busy"}, {31'd0, bus.ra_busy}, {31'd0, exp_busy(bus.ra_addr)});
    chk({tag, " rb_busy"}, {31'd0, bus.rb_busy}, {31'd0, exp_busy(bus.rb_addr)});
    chk({tag, " rc_busy"}, {31'd0, bus.rc_busy}, {31'd0, exp_busy(bus.rc_addr)});
    chk({tag, " err_waw"}, {31'd0, bus.err_waw}, {31'd0, m_err});
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0};
    vt[2]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 32'h22,       1'b0, 1'b0};
    vt[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 32'h0,        1'b1, 1'b0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 5'd9, 32'hAA,       1'b0, 1'b0};
    vt[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hBB, 1'b1, 5'd9, 5'd9, 32'hBB,       1'b1, 1'b0};
    vt[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'hCC, 1'b0, 5'd0, 5'd9, 32'hCC,       1'b0, 1'b0};
    vt[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 32'h0,        1'b1, 1'b0};
    vt[8]  = '{1'b1, 5'd3, 32'h55,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 5'd3, 32'h55,       1'b1, 1'b1};
    vt[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 32'h55,       1'b1, 1'b1};
    vt[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 5'd0, 32'h0,        1'b0, 1'b1};

    idle();
    set_rd('0, '0, '0);
    model_reset();
    reset = 1'b1;
    // A write held during reset must be dropped; read ports stay 0.
    bus.w0_en = 1'b1; bus.w0_addr = 5'd4; bus.w0_data = 32'hCAFE0004;
    bus.w1_en = 1'b1; bus.w1_addr = 5'd4; bus.w1_data = 32'hCAFE0044;
    set_rd(5'd4, 5'd4, 5'd4);
    cycle();
    cycle();
    check_all("in_reset");
    idle();
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      set_rd(i[AW-1:0], i[AW-1:0], i[AW-1:0]);
      #1;
      chk($sformatf("rst ra_data[%0d]", i), bus.ra_data, 32'h0);
      chk($sformatf("rst rb_data[%0d]", i), bus.rb_data, 32'h0);
      chk($sformatf("rst rc_data[%0d]", i), bus.rc_data, 32'h0);
      chk($sformatf("rst busy[%0d]", i), {29'd0, bus.ra_busy, bus.rb_busy, bus.rc_busy}, 32'h0);
    end
    chk("rst err_waw", {31'd0, bus.err_waw}, 32'h0);

    // Directed vectors: apply writes for one edge, then read back on all ports.
    for (int i = 0; i < 11; i++) begin
      bus.w0_en = vt[i].w0_en; bus.w0_addr = vt[i].w0_addr; bus.w0_data = vt[i].w0_data;
      bus.w1_en = vt[i].w1_en; bus.w1_addr = vt[i].w1_addr; bus.w1_data = vt[i].w1_data;
      bus.bs_en = vt[i].bs_en; bus.bs_addr = vt[i].bs_addr;
      cycle();
      idle();
      set_rd(vt[i].rd_addr, vt[i].rd_addr, vt[i].rd_addr);
      #1;
      chk($sformatf("vec%0d ra_data", i), bus.ra_data, vt[i].exp_data);
      chk($sformatf("vec%0d rb_data", i), bus.rb_data, vt[i].exp_data);
      chk($sformatf("vec%0d rc_data", i), bus.rc_data, vt[i].exp_data);
      chk($sformatf("vec%0d ra_busy", i), {31'd0, bus.ra_busy}, {31'd0, vt[i].exp_busy});
      chk($sformatf("vec%0d rc_busy", i), {31'd0, bus.rc_busy}, {31'd0, vt[i].exp_busy});
      chk($sformatf("vec%0d err_waw", i), {31'd0, bus.err_waw}, {31'd0, vt[i].exp_err});
    end

    // Same-cycle read of a colliding write: forwarded or old value.
    bus.w0_en = 1'b1; bus.w0_addr = 5'd7; bus.w0_data = 32'h33;
    bus.w1_en = 1'b1; bus.w1_addr = 5'd7; bus.w1_data = 32'h44;
    set_rd(5'd7, 5'd7, 5'd0);
    #1;
`ifdef GPR_BYPASS_EN
    chk("rdw r7 same cycle", bus.ra_data, 32'h44);
`else
    chk("rdw r7 same cycle", bus.ra_data, 32'h22);
`endif
    chk("rdw r0 never forwarded", bus.rc_data, 32'h0);
    cycle();
    idle();
    #1;
    chk("rdw r7 next cycle", bus.ra_data, 32'h44);

    // Busy forwarding from a same-cycle w1 clear.
    bus.bs_en = 1'b1; bus.bs_addr = 5'd12;
    cycle();
    idle();
    bus.w1_en = 1'b1; bus.w1_addr = 5'd12; bus.w1_data = 32'h12;
    set_rd(5'd12, 5'd12, 5'd12);
    #1;
`ifdef GPR_BYPASS_EN
    chk("busy r12 same-cycle clear", {31'd0, bus.rb_busy}, 32'h0);
`else
    chk("busy r12 same-cycle clear", {31'd0, bus.rb_busy}, 32'h1);
`endif
    cycle();
    idle();
    #1;
    chk("busy r12 after clear", {31'd0, bus.rb_busy}, 32'h0);

    // Sticky error survives idle cycles, then drops on async reset without an edge.
    for (int i = 0; i < 10; i++) cycle();
    set_rd(5'd3, 5'd3, 5'd3);
    #1;
    chk("err_waw sticky", {31'd0, bus.err_waw}, 32'h1);
    chk("r3 before reset", bus.ra_data, 32'h55);
    @(posedge clk);
    model_clock();
    #3;
    reset = 1'b1;
    #1;
    chk("async reset err_waw", {31'd0, bus.err_waw}, 32'h0);
    chk("async reset r3", bus.ra_data, 32'h0);
    model_reset();
    cycle();
    reset = 1'b0;
    #1;
    chk("after reset r3", bus.rb_data, 32'h0);

    // Random traffic on a narrow address range to provoke collisions and hazards.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 75) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rand_reset");
        cycle();
        reset = 1'b0;
      end
      bus.w0_en   = ($urandom_range(0, 1) == 1);
      bus.w0_addr = AW'($urandom_range(0, 7));
      bus.w0_data = $urandom;
      bus.w1_en   = ($urandom_range(0, 2) == 0);
      bus.w1_addr = AW'($urandom_range(0, 7));
      bus.w1_data = $urandom;
      bus.bs_en   = ($urandom_range(0, 2) == 0);
      bus.bs_addr = AW'($urandom_range(0, 7));
      set_rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, N - 1)));
      #1;
      check_all($sformatf("rand%0d", i));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
